aes_inv_key_sched: RTL and testbench
====================================

// Module: aes_inv_key_sched
// PURPOSE
//  Sequential AES-128 inverse key schedule for the decryption datapath.
//  Takes the round-10 key and walks the schedule backwards, one round per transfer.
//  Emits round keys 10,9,...,0 on a valid/ready stream into the inverse-cipher round engine.
//  Mirror of the forward one-round expansion step; reuses the existing Sbox.
// PARAMETERS
//  NUM_ROUNDS  10   AES-128 round count; only 10 is supported (elaboration error otherwise)
//  KEY_W       128  key/round-key width; fixed at 128
// PORTS
//  clk       in   1    single clock; all state changes on posedge
//  rst       in   1    synchronous, active-high reset
//  start     in   1    request; accepted only in IDLE
//  key_in    in   128  round-10 key (cipher key if INVKEY_FWD_PREPASS_EN), sampled on accept
//  busy      out  1    high from accept until the round-0 key transfers
//  rk_valid  out  1    rk_data/rk_round valid
//  rk_ready  in   1    consumer accepts the current round key
//  rk_data   out  128  round key, w0 in [127:96] ... w3 in [31:0]
//  rk_round  out  4    round index of rk_data (10 down to 0)
//  done      out  1    one-cycle pulse after the round-0 transfer
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, rk_valid=0, rk_data=0, rk_round=0, done=0.
//  FSM: IDLE -start-> EMIT; EMIT -xfer & rk_round==0-> IDLE (done=1 next cycle), else stays EMIT.
//  Accept: start & IDLE -> next cycle rk_data=key_in, rk_round=10, rk_valid=1, busy=1.
//  Transfer = rk_valid & rk_ready. On transfer with rk_round=r>0: next cycle rk_data=InvStep(rk_data,r),
//   rk_round=r-1, rk_valid stays 1 (zero-bubble stream: 11 keys in 11 cycles with rk_ready tied high).
//  InvStep(k,r) with k={w4,w5,w6,w7}: w3=w7^w6; w2=w6^w5; w1=w5^w4; w0=w4^SubWord(RotWord(w3))^RCON[r].
//   RotWord = rotate left one byte; SubWord = Sbox per byte; RCON[1..10]=01,02,04,08,10,20,40,80,1b,36 (<<24).
//  Stall: rk_valid=1 & rk_ready=0 -> rk_data, rk_round held stable, no advance.
//  Transfer at rk_round=0: next cycle rk_valid=0, busy=0, done=1 (one cycle), state IDLE.
//  start while busy: ignored, key_in not sampled. start in the done cycle: accepted (state is IDLE).
//  rst mid-stream: synchronous abort to the reset values; no done pulse; partial keys discarded.
//  rk_ready while rk_valid=0: no effect.
// CONFIGURATION
//  INVKEY_FWD_PREPASS_EN defined: key_in is the cipher (round-0) key. State FWD runs 10 forward steps,
//   one per cycle (RCON[1..10]), before EMIT. rk_valid first rises 11 cycles after accept; busy=1 throughout FWD.
//   rst in FWD aborts as above.
//  Not defined: no FWD state; key_in must be the round-10 key; first rk_valid 1 cycle after accept.
//  Emission order, handshake and data are identical in both builds.
// STRUCTURE
//  Package aes_key_pkg: NUM_ROUNDS, RCON table/function indexed 1..10, FSM state enum (IDLE, FWD, EMIT).
//  Sub-module aes_inv_key_step: combinational InvStep(k,r); instantiates Sbox x4 on RotWord(w3).
//  The forward prepass (feature on) uses the existing KeyExpansion with round=r-1, muxed via the same register.
//  Top: FSM, round counter, 128-bit key register, output handshake.
// TESTING
//  FIPS-197 A.1: start, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> rk_round 10..0 on consecutive
//   cycles; round 9=ac7766f319fadc2128d12941575c006e; round 1=a0fafe1788542cb123a339392a6c7605;
//   round 0=2b7e151628aed2a6abf7158809cf4f3c; done one cycle after round 0.
//  Backpressure: rk_ready low for 3 cycles while rk_round=9 -> rk_data/rk_round stable; sequence then resumes
//   unchanged; no key skipped or duplicated.
//  start pulsed during EMIT with a different key_in -> ignored; output matches the first key's schedule.
//  rst asserted at rk_round=5 -> next cycle all outputs 0, no done; new start with the A.1 key gives the full
//   correct sequence.
//  Back-to-back: start asserted in the done cycle -> accepted; round 10 key valid next cycle.
//  INVKEY_FWD_PREPASS_EN build: key_in=2b7e151628aed2a6abf7158809cf4f3c -> after 10 FWD cycles round 10 =
//   d014f9a8c9ee2589e13f0cc8b6630ca6, then the same sequence as test 1.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES-128 key schedule: round constants, Sbox, FSM states.
// Optional macro INVKEY_FWD_PREPASS_EN enables the forward prepass helpers in use by the top.
package aes_key_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // FIPS-197 Sbox, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

    // Forward expansion: round-(r-1) key in, round-r key out.
    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w4, w5, w6, w7;
        w4 = k[127:96] ^ sub_rot_word(k[31:0]) ^ rcon(r);
        w5 = w4 ^ k[95:64];
        w6 = w5 ^ k[63:32];
        w7 = w6 ^ k[31:0];
        return {w4, w5, w6, w7};
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// Combinational inverse key-expansion step: round-r key in, round-(r-1) key out.
module aes_inv_key_step
    import aes_key_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [3:0]   round,
    output logic [127:0] key_out
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;

    // Undo the word chaining first; w0 needs the recovered w3.
    always_comb begin
        w3_s    = key_in[31:0]  ^ key_in[63:32];
        w2_s    = key_in[63:32] ^ key_in[95:64];
        w1_s    = key_in[95:64] ^ key_in[127:96];
        w0_s    = key_in[127:96] ^ sub_rot_word(w3_s) ^ rcon(round);
        key_out = {w0_s, w1_s, w2_s, w3_s};
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: streams round keys 10..0 on a valid/ready interface.
// Define INVKEY_FWD_PREPASS_EN to accept the cipher key and expand it forward before streaming.
module aes_inv_key_sched
    import aes_key_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [3:0]       rk_round,
    output logic             done
);

    if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_param_check
        $error("aes_inv_key_sched supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
    end

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       round_q, round_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] inv_key_s;

    aes_inv_key_step u_step (
        .key_in  (key_q),
        .round   (round_q),
        .key_out (inv_key_s)
    );

    // Next-state logic; the key register doubles as the forward-prepass accumulator.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d  = key_in;
                    busy_d = 1'b1;
`ifdef INVKEY_FWD_PREPASS_EN
                    state_d = FWD;
                    round_d = 4'd0;
                    valid_d = 1'b0;
`else
                    state_d = EMIT;
                    round_d = 4'd10;
                    valid_d = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef INVKEY_FWD_PREPASS_EN
            FWD: begin
                key_d = fwd_step(key_q, round_q + 4'd1);
                if (round_q == 4'd9) begin
                    state_d = EMIT;
                    round_d = 4'd10;
                    valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
`endif
            EMIT: begin
                if (valid_q && rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = inv_key_s;
                        round_d = round_q - 4'd1;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = valid_q;
    assign rk_data  = key_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 A.1 key schedule as the reference table.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] data;
    } vec_t;

    vec_t tbl [11];

`ifdef INVKEY_FWD_PREPASS_EN
    localparam int            FIRST_LAT = 10;
    localparam logic [127:0]  START_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
    localparam int            FIRST_LAT = 0;
    localparam logic [127:0]  START_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, {127'd0, rk_valid}, 128'd0);
        chk({tag, "_busy"},  {127'd0, busy},     128'd0);
        chk({tag, "_done"},  {127'd0, done},     128'd0);
        chk({tag, "_data"},  rk_data,            128'd0);
        chk({tag, "_round"}, {124'd0, rk_round}, 128'd0);
    endtask

    // Pulse start for one cycle, then wait (bounded) for the first round key.
    task automatic start_stream(input logic [127:0] k);
        int n;
        start  = 1'b1;
        key_in = k;
        tick;
        start  = 1'b0;
        key_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        chk("start_done_low", {127'd0, done}, 128'd0);
        chk("start_busy", {127'd0, busy}, 128'd1);
        n = 0;
        while (!rk_valid && n < 20) begin
            chk("prepass_busy", {127'd0, busy}, 128'd1);
            tick;
            n++;
        end
        chk("first_valid_latency", 128'(n), 128'(FIRST_LAT));
    endtask

    // Walk the table with rk_ready high, optionally stalling, poking start, or aborting.
    task automatic walk(input int stall_round, input int stall_n, input int poke_round,
                        input int abort_round);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("valid_r%0d", tbl[i].round), {127'd0, rk_valid}, 128'd1);
            chk($sformatf("busy_r%0d", tbl[i].round),  {127'd0, busy},     128'd1);
            chk($sformatf("round_r%0d", tbl[i].round), {124'd0, rk_round}, {124'd0, tbl[i].round});
            chk($sformatf("data_r%0d", tbl[i].round),  rk_data,            tbl[i].data);
            if (int'(tbl[i].round) == abort_round) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                chk_idle_zero("abort");
                tick;
                chk_idle_zero("abort_after");
                return;
            end
            if (int'(tbl[i].round) == stall_round) begin
                rk_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick;
                    chk("stall_valid", {127'd0, rk_valid}, 128'd1);
                    chk("stall_round", {124'd0, rk_round}, {124'd0, tbl[i].round});
                    chk("stall_data",  rk_data,            tbl[i].data);
                end
                rk_ready = 1'b1;
            end
            if (int'(tbl[i].round) == poke_round) begin
                start  = 1'b1;
                key_in = 128'h00112233445566778899aabbccddeeff;
            end
            tick;
            start = 1'b0;
        end
        chk("end_done",  {127'd0, done},     128'd1);
        chk("end_valid", {127'd0, rk_valid}, 128'd0);
        chk("end_busy",  {127'd0, busy},     128'd0);
    endtask

    initial begin
        tbl[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        rst      = 1'b1;
        start    = 1'b0;
        key_in   = 128'd0;
        rk_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk_idle_zero("reset");
        tick;
        chk_idle_zero("reset_idle");

        // Plain stream; done must fall one cycle later.
        start_stream(START_KEY);
        walk(-1, 0, -1, -1);
        tick;
        chk("done_pulse_width", {127'd0, done}, 128'd0);

        // Backpressure at round 9.
        start_stream(START_KEY);
        walk(9, 3, -1, -1);
        tick;

        // Start with another key during emission must be ignored.
        start_stream(START_KEY);
        walk(-1, 0, 6, -1);
        tick;
        chk("poke_no_restart", {127'd0, rk_valid}, 128'd0);

        // Abort at round 5, then a full run, then back-to-back start in the done cycle.
        start_stream(START_KEY);
        walk(-1, 0, -1, 5);
        start_stream(START_KEY);
        walk(-1, 0, -1, -1);
        start_stream(START_KEY);
        walk(-1, 0, -1, -1);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
